// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost sprite mover: FSM states, VEL word
// field positions and coordinate widths.
// Build option: GHOST_MOVER_BOUNCE_EN selects reflecting edges (adds WR_V).
package ghost_pkg;

   localparam int COORD_W = 10;
   localparam int CALC_W  = COORD_W + 2;
   localparam int VEL_W   = 16;
   localparam int VX_LSB  = 0;
   localparam int VX_MSB  = 15;
   localparam int VY_LSB  = 16;
   localparam int VY_MSB  = 31;

   typedef enum logic [3:0] {
      IDLE,
      RD_X,
      WT_X,
      RD_Y,
      WT_Y,
      RD_V,
      WT_V,
      CALC,
      WR_X,
      WR_Y,
`ifdef GHOST_MOVER_BOUNCE_EN
      WR_V,
`endif
      FIN
   } state_t;

   // Positions are kept in the wider arithmetic width internally and are
   // always in range when written, so plain zero extension is correct.
   function automatic logic [31:0] coord_to_word(input logic [CALC_W-1:0] c);
      return 32'(c);
   endfunction

endpackage

// File: rtl/ghost_axis_step.sv
// One axis of the ghost movement: adds the velocity to the position and
// folds the result back into [0, MAX] by wrapping, or by reflecting and
// negating the velocity when GHOST_MOVER_BOUNCE_EN is defined.
module ghost_axis_step
   import ghost_pkg::*;
#(
   parameter int MAX = 639
) (
   input  logic        [CALC_W-1:0] pos,
   input  logic signed [VEL_W-1:0]  vel,
   output logic        [CALC_W-1:0] new_pos,
   output logic signed [VEL_W-1:0]  new_vel
);

   localparam logic signed [CALC_W-1:0] ZERO  = '0;
   localparam logic signed [CALC_W-1:0] LIMIT = CALC_W'(MAX);
`ifdef GHOST_MOVER_BOUNCE_EN
   localparam logic signed [CALC_W-1:0] TWICE = CALC_W'(2 * MAX);
`else
   localparam logic signed [CALC_W-1:0] SPAN  = CALC_W'(MAX + 1);
`endif

   logic signed [CALC_W-1:0] sum;

   // Speeds are bounded well below the 12-bit range, so only the low bits of vel matter here.
   assign sum = $signed(pos) + $signed(vel[CALC_W-1:0]);

   // Fold an out-of-range coordinate back onto the playfield.
   always_comb begin
      new_pos = sum;
      new_vel = vel;
`ifdef GHOST_MOVER_BOUNCE_EN
      if (sum < ZERO) begin
         new_pos = -sum;
         new_vel = -vel;
      end else if (sum > LIMIT) begin
         new_pos = TWICE - sum;
         new_vel = -vel;
      end
`else
      if (sum < ZERO) begin
         new_pos = sum + SPAN;
      end else if (sum > LIMIT) begin
         new_pos = sum - SPAN;
      end
`endif
   end

endmodule

// File: rtl/ghost_mover.sv
// Ghost mover: on each frame tick reads X, Y and VEL from a register file
// over Avalon-MM (read latency 1), steps both axes and writes the result back.
// Build option: GHOST_MOVER_BOUNCE_EN reflects at the edges and writes VEL back.
module ghost_mover
   import ghost_pkg::*;
#(
   parameter int         X_MAX    = 639,
   parameter int         Y_MAX    = 479,
   parameter logic [5:0] ADDR_X   = 6'd0,
   parameter logic [5:0] ADDR_Y   = 6'd1,
   parameter logic [5:0] ADDR_VEL = 6'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   output logic        avl_read,
   output logic        avl_write,
   output logic        avl_cs,
   output logic [3:0]  avl_byte_en,
   output logic [5:0]  avl_addr,
   output logic [31:0] avl_writedata,
   input  logic [31:0] avl_readdata,
   input  logic        avl_waitrequest,
   output logic        busy,
   output logic        done,
   output logic [7:0]  overrun_cnt
);

   state_t                   state;
   logic        [CALC_W-1:0] pos_x;
   logic        [CALC_W-1:0] pos_y;
   logic signed [VEL_W-1:0]  vel_x;
   logic signed [VEL_W-1:0]  vel_y;
   logic        [CALC_W-1:0] next_x;
   logic        [CALC_W-1:0] next_y;
   logic signed [VEL_W-1:0]  next_vx;
   logic signed [VEL_W-1:0]  next_vy;

   ghost_axis_step #(.MAX(X_MAX)) u_step_x (
      .pos     (pos_x),
      .vel     (vel_x),
      .new_pos (next_x),
      .new_vel (next_vx)
   );

   ghost_axis_step #(.MAX(Y_MAX)) u_step_y (
      .pos     (pos_y),
      .vel     (vel_y),
      .new_pos (next_y),
      .new_vel (next_vy)
   );

   // Update sequencer: bus strobes are registered and changed on the accept edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         avl_read      <= 1'b0;
         avl_write     <= 1'b0;
         avl_cs        <= 1'b0;
         avl_byte_en   <= 4'h0;
         avl_addr      <= 6'd0;
         avl_writedata <= 32'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pos_x         <= '0;
         pos_y         <= '0;
         vel_x         <= '0;
         vel_y         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_tick) begin
                  state       <= RD_X;
                  busy        <= 1'b1;
                  avl_cs      <= 1'b1;
                  avl_read    <= 1'b1;
                  avl_byte_en <= 4'hF;
                  avl_addr    <= ADDR_X;
               end
            end
            RD_X, RD_Y, RD_V: begin
               if (!avl_waitrequest) begin
                  state       <= (state == RD_X) ? WT_X : (state == RD_Y) ? WT_Y : WT_V;
                  avl_cs      <= 1'b0;
                  avl_read    <= 1'b0;
                  avl_byte_en <= 4'h0;
               end
            end
            WT_X: begin
               pos_x       <= {2'b00, avl_readdata[COORD_W-1:0]};
               state       <= RD_Y;
               avl_cs      <= 1'b1;
               avl_read    <= 1'b1;
               avl_byte_en <= 4'hF;
               avl_addr    <= ADDR_Y;
            end
            WT_Y: begin
               pos_y       <= {2'b00, avl_readdata[COORD_W-1:0]};
               state       <= RD_V;
               avl_cs      <= 1'b1;
               avl_read    <= 1'b1;
               avl_byte_en <= 4'hF;
               avl_addr    <= ADDR_VEL;
            end
            WT_V: begin
               vel_x <= avl_readdata[VX_MSB:VX_LSB];
               vel_y <= avl_readdata[VY_MSB:VY_LSB];
               state <= CALC;
            end
            CALC: begin
               pos_x         <= next_x;
               pos_y         <= next_y;
               vel_x         <= next_vx;
               vel_y         <= next_vy;
               state         <= WR_X;
               avl_cs        <= 1'b1;
               avl_write     <= 1'b1;
               avl_byte_en   <= 4'hF;
               avl_addr      <= ADDR_X;
               avl_writedata <= coord_to_word(next_x);
            end
            WR_X: begin
               if (!avl_waitrequest) begin
                  state         <= WR_Y;
                  avl_addr      <= ADDR_Y;
                  avl_writedata <= coord_to_word(pos_y);
               end
            end
            WR_Y: begin
               if (!avl_waitrequest) begin
`ifdef GHOST_MOVER_BOUNCE_EN
                  state         <= WR_V;
                  avl_addr      <= ADDR_VEL;
                  avl_writedata <= {vel_y, vel_x};
`else
                  state       <= FIN;
                  avl_cs      <= 1'b0;
                  avl_write   <= 1'b0;
                  avl_byte_en <= 4'h0;
                  done        <= 1'b1;
`endif
               end
            end
`ifdef GHOST_MOVER_BOUNCE_EN
            WR_V: begin
               if (!avl_waitrequest) begin
                  state       <= FIN;
                  avl_cs      <= 1'b0;
                  avl_write   <= 1'b0;
                  avl_byte_en <= 4'h0;
                  done        <= 1'b1;
               end
            end
`endif
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Count ticks that arrive while an update is already running, saturating.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_cnt <= 8'd0;
      end else if (frame_tick && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with a latency-1 Avalon slave model,
// a write scoreboard and immediate-assertion checks.
module tb_ghost_mover;

`ifdef GHOST_MOVER_BOUNCE_EN
   localparam int BASE = 11;
`else
   localparam int BASE = 10;
`endif
   localparam int X_MAX = 639;
   localparam int Y_MAX = 479;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        avl_read;
   logic        avl_write;
   logic        avl_cs;
   logic [3:0]  avl_byte_en;
   logic [5:0]  avl_addr;
   logic [31:0] avl_writedata;
   logic [31:0] avl_readdata;
   logic        avl_waitrequest;
   logic        busy;
   logic        done;
   logic [7:0]  overrun_cnt;

   logic [31:0] mem [0:63];
   int          stall_rd [0:63];
   int          stall_wr [0:63];
   wr_t         exp_q [$];
   wr_t         obs_q [$];
   int          obs_rd = 0;
   int          viol = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ghost_mover dut (
      .clk             (clk),
      .reset           (reset),
      .frame_tick      (frame_tick),
      .avl_read        (avl_read),
      .avl_write       (avl_write),
      .avl_cs          (avl_cs),
      .avl_byte_en     (avl_byte_en),
      .avl_addr        (avl_addr),
      .avl_writedata   (avl_writedata),
      .avl_readdata    (avl_readdata),
      .avl_waitrequest (avl_waitrequest),
      .busy            (busy),
      .done            (done),
      .overrun_cnt     (overrun_cnt)
   );

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference movement for one axis, written straight from the wrap/bounce rules.
   function automatic void model_axis(input int pos, input int vel, input int maxv,
                                      output int npos, output int nvel);
      int s;
      s    = pos + vel;
      npos = s;
      nvel = vel;
`ifdef GHOST_MOVER_BOUNCE_EN
      if (s < 0) begin
         npos = -s;
         nvel = -vel;
      end else if (s > maxv) begin
         npos = 2 * maxv - s;
         nvel = -vel;
      end
`else
      if (s < 0) npos = s + maxv + 1;
      else if (s > maxv) npos = s - (maxv + 1);
`endif
   endfunction

   // Avalon slave: decides waitrequest, returns read data one cycle after
   // accept, logs accepted writes and counts protocol violations.
   initial begin
      logic       prev_wait;
      logic [5:0] s_addr;
      logic       s_rd;
      logic       s_wr;
      logic [31:0] s_wd;
      logic       pend;
      logic [5:0] pend_addr;
      logic       in_txn;
      int         cur;
      prev_wait = 1'b0;
      pend = 1'b0;
      pend_addr = '0;
      in_txn = 1'b0;
      cur = 0;
      s_addr = '0;
      s_rd = 1'b0;
      s_wr = 1'b0;
      s_wd = '0;
      avl_waitrequest = 1'b0;
      avl_readdata = 32'hDEADBEEF;
      forever begin
         @(negedge clk);
         avl_readdata = pend ? mem[pend_addr] : 32'hDEADBEEF;
         pend = 1'b0;
         if (reset) begin
            prev_wait = 1'b0;
            in_txn = 1'b0;
            avl_waitrequest = 1'b0;
         end else begin
            if (avl_read && avl_write) viol++;
            if (avl_cs !== (avl_read | avl_write)) viol++;
            if (avl_cs && avl_byte_en !== 4'hF) viol++;
            if (prev_wait && (avl_addr !== s_addr || avl_read !== s_rd ||
                              avl_write !== s_wr || avl_writedata !== s_wd || !avl_cs)) viol++;
            if (avl_cs) begin
               if (!in_txn) begin
                  in_txn = 1'b1;
                  cur = avl_read ? stall_rd[avl_addr] : stall_wr[avl_addr];
               end
               if (cur > 0) begin
                  cur--;
                  avl_waitrequest = 1'b1;
               end else begin
                  avl_waitrequest = 1'b0;
                  in_txn = 1'b0;
                  if (avl_read) begin
                     pend = 1'b1;
                     pend_addr = avl_addr;
                  end else begin
                     obs_q.push_back({avl_addr, avl_writedata});
                  end
               end
            end else begin
               avl_waitrequest = 1'b0;
               in_txn = 1'b0;
            end
            prev_wait = avl_waitrequest;
            s_addr = avl_addr;
            s_rd = avl_read;
            s_wr = avl_write;
            s_wd = avl_writedata;
         end
      end
   end

   // One full update: preload registers, push expected writes, tick, and
   // check latency, DONE pulse, overrun-free ticks and the write stream.
   task automatic applyStimulus(input string tag, input int x, input int y, input int vx,
                                input int vy, input int exp_cycles, input int drop);
      int  nx, ny, nvx, nvy, cycles, v0;
      wr_t e, o;
      mem[0] = 32'(x);
      mem[1] = 32'(y);
      mem[2] = {16'(vy), 16'(vx)};
      model_axis(x, vx, X_MAX, nx, nvx);
      model_axis(y, vy, Y_MAX, ny, nvy);
      exp_q.push_back({6'd0, 32'(nx)});
      exp_q.push_back({6'd1, 32'(ny)});
`ifdef GHOST_MOVER_BOUNCE_EN
      exp_q.push_back({6'd2, 16'(nvy), 16'(nvx)});
`endif
      v0 = viol;
      @(negedge clk);
      frame_tick = 1'b1;
      cycles = 0;
      while (1) begin
         @(negedge clk);
         cycles++;
         frame_tick = (cycles <= drop);
         if (done === 1'b1 || cycles > exp_cycles + 20) break;
      end
      frame_tick = 1'b0;
      checkOutput({tag, " done_latency"}, 32'(cycles), 32'(exp_cycles));
      checkOutput({tag, " busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      checkOutput({tag, " done_pulse"}, {30'd0, done, busy}, 32'd0);
      checkOutput({tag, " write_count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_rd < obs_q.size()) begin
            o = obs_q[obs_rd];
            obs_rd++;
         end else begin
            o = 'x;
         end
         checkOutput({tag, " wr_addr"}, 32'(o.addr), 32'(e.addr));
         checkOutput({tag, " wr_data"}, o.data, e.data);
      end
      checkOutput({tag, " protocol"}, 32'(viol - v0), 32'd0);
   endtask

   initial begin
      int guard;
      int seen;
      reset = 1'b1;
      frame_tick = 1'b0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = '0;
         stall_rd[i] = 0;
         stall_wr[i] = 0;
      end
      repeat (3) @(negedge clk);
      checkOutput("reset strobes", {29'd0, avl_cs, avl_read, avl_write}, 32'd0);
      checkOutput("reset bus", {avl_byte_en, avl_addr}, 32'd0);
      checkOutput("reset wdata", avl_writedata, 32'd0);
      checkOutput("reset status", {22'd0, busy, done, overrun_cnt}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      applyStimulus("basic", 630, 100, 20, -5, BASE, 0);
      applyStimulus("negedge", 5, 2, -10, -5, BASE, 0);
      applyStimulus("zero", 0, 0, 0, 0, BASE, 0);
      applyStimulus("max", 639, 479, 0, 0, BASE, 0);
      applyStimulus("land_max", 600, 470, 39, 9, BASE, 0);
      checkOutput("overrun idle", 32'(overrun_cnt), 32'd0);

      stall_rd[1] = 3;
      stall_wr[0] = 2;
      applyStimulus("stall", 630, 100, 20, -5, BASE + 5, 0);
      stall_rd[1] = 0;
      stall_wr[0] = 0;

      applyStimulus("overrun3", 630, 100, 20, -5, BASE, 3);
      checkOutput("overrun 3", 32'(overrun_cnt), 32'd3);

      stall_rd[1] = 320;
      applyStimulus("flood", 100, 200, -3, 4, BASE + 320, 300);
      stall_rd[1] = 0;
      checkOutput("overrun sat", 32'(overrun_cnt), 32'd255);

      // Abort an update while it is stalled in the X write.
      stall_wr[0] = 10;
      mem[0] = 32'd630;
      mem[1] = 32'd100;
      mem[2] = {16'hFFFB, 16'd20};
      seen = obs_q.size();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      guard = 0;
      while (!(avl_write === 1'b1 && avl_addr === 6'd0) && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("abort reached WR_X", 32'(guard < 30), 32'd1);
      #2 reset = 1'b1;
      @(negedge clk);
      checkOutput("abort strobes", {29'd0, avl_cs, avl_read, avl_write}, 32'd0);
      checkOutput("abort bus", {avl_byte_en, avl_addr}, 32'd0);
      checkOutput("abort wdata", avl_writedata, 32'd0);
      checkOutput("abort status", {22'd0, busy, done, overrun_cnt}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      stall_wr[0] = 0;
      repeat (12) @(negedge clk);
      checkOutput("abort no writes", 32'(obs_q.size() - seen), 32'd0);
      checkOutput("abort stays idle", {31'd0, busy}, 32'd0);
      obs_rd = obs_q.size();

      applyStimulus("post_reset", 630, 100, 20, -5, BASE, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
